// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter granting two read requesters
// (m0 = instruction fetch, m1 = data/stack) access to a single ROM port.
// One ROM transaction is in flight at a time: IDLE -> ADDR -> DATA -> IDLE.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   mX_req                     read request, held by requester until mX_gnt
//   mX_addr, mX_extra          byte address and access size code
//   mX_lower/upper_bound       legal address window of the requester
//   mX_gnt                     one-cycle pulse: request accepted
//   mX_rvalid                  one-cycle pulse: mX_rdata / mX_error valid
//   mX_rdata, mX_error         read data (held until next rvalid), ROM error
//   mem_addr, mem_extra        registered ROM address / size of current owner
//   mem_lower/upper_bound      registered bounds of current owner
//   mem_data, mem_error        ROM response, valid one cycle after mem_addr sampled
module mem_arbiter #(
    parameter int unsigned MEM_ADDR  = 4,
    parameter int unsigned MEM_EXTRA = 4
) (
    input  logic                            clk,
    input  logic                            reset,

    input  logic                            m0_req,
    input  logic [MEM_ADDR:0]               m0_addr,
    input  logic [MEM_EXTRA-1:0]            m0_extra,
    input  logic [MEM_ADDR:0]               m0_lower_bound,
    input  logic [MEM_ADDR:0]               m0_upper_bound,
    output logic                            m0_gnt,
    output logic                            m0_rvalid,
    output logic [(2**MEM_EXTRA)*8-1:0]     m0_rdata,
    output logic                            m0_error,

    input  logic                            m1_req,
    input  logic [MEM_ADDR:0]               m1_addr,
    input  logic [MEM_EXTRA-1:0]            m1_extra,
    input  logic [MEM_ADDR:0]               m1_lower_bound,
    input  logic [MEM_ADDR:0]               m1_upper_bound,
    output logic                            m1_gnt,
    output logic                            m1_rvalid,
    output logic [(2**MEM_EXTRA)*8-1:0]     m1_rdata,
    output logic                            m1_error,

    output logic [MEM_ADDR:0]               mem_addr,
    output logic [MEM_EXTRA-1:0]            mem_extra,
    output logic [MEM_ADDR:0]               mem_lower_bound,
    output logic [MEM_ADDR:0]               mem_upper_bound,
    input  logic [(2**MEM_EXTRA)*8-1:0]     mem_data,
    input  logic                            mem_error
);

    localparam int unsigned AW = MEM_ADDR + 1;
    localparam int unsigned DW = (2**MEM_EXTRA) * 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    // Request payload latched into the mem_* registers on a grant.
    typedef struct packed {
        logic [AW-1:0]        addr;
        logic [MEM_EXTRA-1:0] extra;
        logic [AW-1:0]        lower_bound;
        logic [AW-1:0]        upper_bound;
    } req_t;

    state_t state;
    logic   owner;       // requester of the in-flight access
    logic   last_owner;  // requester granted most recently

    logic   any_req_c;
    logic   pick_m1_c;
    req_t   win_c;

    // Round-robin choice: lone requester wins; on a tie the one not granted last wins.
    always_comb begin
        any_req_c = m0_req | m1_req;
        pick_m1_c = m1_req & (~m0_req | ~last_owner);
        win_c     = '0;
        if (pick_m1_c) begin
            win_c.addr        = m1_addr;
            win_c.extra       = m1_extra;
            win_c.lower_bound = m1_lower_bound;
            win_c.upper_bound = m1_upper_bound;
        end else begin
            win_c.addr        = m0_addr;
            win_c.extra       = m0_extra;
            win_c.lower_bound = m0_lower_bound;
            win_c.upper_bound = m0_upper_bound;
        end
    end

    // Arbitration FSM with registered grant, response and ROM-side outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            owner           <= 1'b0;
            last_owner      <= 1'b1;
            m0_gnt          <= 1'b0;
            m0_rvalid       <= 1'b0;
            m0_rdata        <= '0;
            m0_error        <= 1'b0;
            m1_gnt          <= 1'b0;
            m1_rvalid       <= 1'b0;
            m1_rdata        <= '0;
            m1_error        <= 1'b0;
            mem_addr        <= '0;
            mem_extra       <= '0;
            mem_lower_bound <= '0;
            mem_upper_bound <= '0;
        end else begin
            // Grant and rvalid are single-cycle pulses.
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;

            case (state)
                IDLE: begin
                    if (any_req_c) begin
                        owner           <= pick_m1_c;
                        last_owner      <= pick_m1_c;
                        mem_addr        <= win_c.addr;
                        mem_extra       <= win_c.extra;
                        mem_lower_bound <= win_c.lower_bound;
                        mem_upper_bound <= win_c.upper_bound;
                        m0_gnt          <= ~pick_m1_c;
                        m1_gnt          <= pick_m1_c;
                        state           <= ADDR;
                    end
                end

                // ROM samples mem_addr at the end of this cycle.
                ADDR: state <= DATA;

                // ROM response is valid now; an errored access returns zero data.
                DATA: begin
                    if (owner) begin
                        m1_rdata  <= mem_error ? DW'(0) : mem_data;
                        m1_error  <= mem_error;
                        m1_rvalid <= 1'b1;
                    end else begin
                        m0_rdata  <= mem_error ? DW'(0) : mem_data;
                        m0_error  <= mem_error;
                        m0_rvalid <= 1'b1;
                    end
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a grant/response scoreboard for mem_arbiter.
module tb_mem_arbiter;

    localparam int unsigned MEM_ADDR  = 4;
    localparam int unsigned MEM_EXTRA = 4;
    localparam int unsigned AW        = MEM_ADDR + 1;
    localparam int unsigned DW        = (2**MEM_EXTRA) * 8;

    logic                 clk;
    logic                 reset;
    logic                 m0_req, m1_req;
    logic [AW-1:0]        m0_addr, m1_addr;
    logic [MEM_EXTRA-1:0] m0_extra, m1_extra;
    logic [AW-1:0]        m0_lower_bound, m0_upper_bound, m1_lower_bound, m1_upper_bound;
    logic                 m0_gnt, m0_rvalid, m0_error, m1_gnt, m1_rvalid, m1_error;
    logic [DW-1:0]        m0_rdata, m1_rdata;
    logic [AW-1:0]        mem_addr, mem_lower_bound, mem_upper_bound;
    logic [MEM_EXTRA-1:0] mem_extra;
    logic [DW-1:0]        mem_data;
    logic                 mem_error;

    mem_arbiter #(.MEM_ADDR(MEM_ADDR), .MEM_EXTRA(MEM_EXTRA)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_extra(m0_extra),
        .m0_lower_bound(m0_lower_bound), .m0_upper_bound(m0_upper_bound),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_error(m0_error),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_extra(m1_extra),
        .m1_lower_bound(m1_lower_bound), .m1_upper_bound(m1_upper_bound),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_error(m1_error),
        .mem_addr(mem_addr), .mem_extra(mem_extra),
        .mem_lower_bound(mem_lower_bound), .mem_upper_bound(mem_upper_bound),
        .mem_data(mem_data), .mem_error(mem_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ROM contents: word 0 is fixed, others are a byte pattern derived from the address.
    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        if (a == '0) return DW'(64'h0123456789ABCDEF);
        return {16{8'(a) + 8'h10}};
    endfunction

    // ROM model: response one cycle after the address is sampled; data is
    // left non-zero on an error so the arbiter's zeroing is observable.
    always @(posedge clk) begin
        mem_data  <= rom_word(mem_addr);
        mem_error <= (mem_addr < mem_lower_bound) || (mem_addr > mem_upper_bound);
    end

    typedef struct {
        int who;
        int cyc;
    } gnt_exp_t;

    typedef struct {
        int            who;
        logic [DW-1:0] data;
        logic          err;
        int            cyc;
    } rv_exp_t;

    gnt_exp_t gq[$];
    rv_exp_t  rq[$];

    gnt_exp_t      mon_g;
    rv_exp_t       mon_r;
    int            mon_who;
    logic [DW-1:0] mon_data;
    logic          mon_err;

    // Monitor: compare every grant and response pulse against the scoreboard.
    always @(negedge clk) begin
        if (m0_gnt && m1_gnt) begin
            checks++; errors++;
            $display("FAIL double_gnt actual both granted at cyc %0d required one", cyc);
        end else if (m0_gnt || m1_gnt) begin
            checks++;
            mon_who = m1_gnt ? 1 : 0;
            if (gq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_gnt actual m%0d at cyc %0d required none", mon_who, cyc);
            end else begin
                mon_g = gq.pop_front();
                if (mon_g.who != mon_who || mon_g.cyc != cyc) begin
                    errors++;
                    $display("FAIL gnt actual m%0d cyc %0d required m%0d cyc %0d",
                             mon_who, cyc, mon_g.who, mon_g.cyc);
                end
            end
        end

        if (m0_rvalid && m1_rvalid) begin
            checks++; errors++;
            $display("FAIL double_rvalid actual both valid at cyc %0d required one", cyc);
        end else if (m0_rvalid || m1_rvalid) begin
            checks++;
            mon_who  = m1_rvalid ? 1 : 0;
            mon_data = m1_rvalid ? m1_rdata : m0_rdata;
            mon_err  = m1_rvalid ? m1_error : m0_error;
            if (rq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rvalid actual m%0d at cyc %0d required none", mon_who, cyc);
            end else begin
                mon_r = rq.pop_front();
                if (mon_r.who != mon_who || mon_r.cyc != cyc ||
                    mon_r.data !== mon_data || mon_r.err !== mon_err) begin
                    errors++;
                    $display("FAIL rvalid actual m%0d cyc %0d data %0h err %0b required m%0d cyc %0d data %0h err %0b",
                             mon_who, cyc, mon_data, mon_err,
                             mon_r.who, mon_r.cyc, mon_r.data, mon_r.err);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Wait for all expected pulses to appear, bounded.
    task automatic drain(input string name);
        for (int i = 0; i < 30 && (gq.size() != 0 || rq.size() != 0); i++) tick();
        checks++;
        if (gq.size() != 0 || rq.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout actual %0d gnt %0d rvalid pending required 0",
                     name, gq.size(), rq.size());
            gq.delete();
            rq.delete();
        end
    endtask

    task automatic set_m0(input logic req, input int a, input int lo, input int hi);
        m0_req = req; m0_addr = AW'(a); m0_lower_bound = AW'(lo); m0_upper_bound = AW'(hi);
    endtask

    task automatic set_m1(input logic req, input int a, input int lo, input int hi);
        m1_req = req; m1_addr = AW'(a); m1_lower_bound = AW'(lo); m1_upper_bound = AW'(hi);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_m0_gnt"},    DW'(m0_gnt),    '0);
        chk({tag, "_m1_gnt"},    DW'(m1_gnt),    '0);
        chk({tag, "_m0_rvalid"}, DW'(m0_rvalid), '0);
        chk({tag, "_m1_rvalid"}, DW'(m1_rvalid), '0);
        chk({tag, "_m0_rdata"},  m0_rdata,       '0);
        chk({tag, "_m1_rdata"},  m1_rdata,       '0);
        chk({tag, "_m0_error"},  DW'(m0_error),  '0);
        chk({tag, "_m1_error"},  DW'(m1_error),  '0);
        chk({tag, "_mem_addr"},  DW'(mem_addr),  '0);
        chk({tag, "_mem_extra"}, DW'(mem_extra), '0);
        chk({tag, "_mem_lb"},    DW'(mem_lower_bound), '0);
        chk({tag, "_mem_ub"},    DW'(mem_upper_bound), '0);
    endtask

    int c;

    initial begin
        reset = 1'b1;
        set_m0(1'b0, 0, 0, 15);
        set_m1(1'b0, 0, 0, 15);
        m0_extra = '0;
        m1_extra = '0;

        // Reset state
        tick(); tick();
        chk_all_zero("reset");
        reset = 1'b0;
        tick();

        // m0 alone: ROM word 0, size 3
        tick(); c = cyc;
        set_m0(1'b1, 0, 0, 15); m0_extra = 4'd3;
        gq.push_back('{who: 0, cyc: c + 1});
        rq.push_back('{who: 0, data: rom_word(0), err: 1'b0, cyc: c + 3});
        tick(); m0_req = 1'b0;
        chk("single_mem_addr",  DW'(mem_addr),  DW'(0));
        chk("single_mem_extra", DW'(mem_extra), DW'(3));
        drain("single");
        chk("single_rdata_hold", m0_rdata, DW'(64'h0123456789ABCDEF));
        m0_extra = '0;

        // Fresh reset so last_owner is 1, then a simultaneous request
        tick(); reset = 1'b1; tick(); reset = 1'b0;
        tick(); c = cyc;
        set_m0(1'b1, 1, 0, 15);
        set_m1(1'b1, 2, 0, 15);
        gq.push_back('{who: 0, cyc: c + 1});
        gq.push_back('{who: 1, cyc: c + 4});
        rq.push_back('{who: 0, data: rom_word(1), err: 1'b0, cyc: c + 3});
        rq.push_back('{who: 1, data: rom_word(2), err: 1'b0, cyc: c + 6});
        tick(); m0_req = 1'b0;
        tick(); tick(); tick(); m1_req = 1'b0;
        drain("tie");

        // Both held for 12 cycles: grants alternate m0, m1, m0, m1
        tick(); c = cyc;
        set_m0(1'b1, 3, 0, 15);
        set_m1(1'b1, 4, 0, 15);
        for (int k = 0; k < 4; k++) begin
            gq.push_back('{who: k % 2, cyc: c + 1 + 3 * k});
            rq.push_back('{who: k % 2, data: rom_word(AW'(3 + k % 2)), err: 1'b0, cyc: c + 3 + 3 * k});
        end
        repeat (12) tick();
        m0_req = 1'b0; m1_req = 1'b0;
        drain("rr");

        // m1 out of window; its inputs change mid-access without effect
        tick(); c = cyc;
        set_m1(1'b1, 5, 0, 3);
        gq.push_back('{who: 1, cyc: c + 1});
        rq.push_back('{who: 1, data: '0, err: 1'b1, cyc: c + 3});
        tick();
        chk("err_mem_ub",   DW'(mem_upper_bound), DW'(3));
        chk("err_mem_addr", DW'(mem_addr),        DW'(5));
        set_m1(1'b0, 0, 0, 15);
        drain("err");
        chk("err_m1_error", DW'(m1_error), DW'(1));
        chk("err_m1_rdata", m1_rdata, '0);
        chk("err_m0_rdata", m0_rdata, rom_word(3));
        chk("err_m0_error", DW'(m0_error), DW'(0));

        // Reset during DATA aborts the m0 access
        tick(); c = cyc;
        set_m0(1'b1, 6, 0, 15);
        gq.push_back('{who: 0, cyc: c + 1});
        tick(); m0_req = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        chk_all_zero("abort");
        tick(); reset = 1'b0;
        tick(); tick();

        // m1 served normally after the abort
        tick(); c = cyc;
        set_m1(1'b1, 7, 0, 15);
        gq.push_back('{who: 1, cyc: c + 1});
        rq.push_back('{who: 1, data: rom_word(7), err: 1'b0, cyc: c + 3});
        tick(); m1_req = 1'b0;
        drain("post_abort");
        chk("post_abort_m1_rdata", m1_rdata, rom_word(7));
        chk("post_abort_m0_rdata", m0_rdata, '0);
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual running required finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_ADDR, default 4: ROM address width minus one (address buses are MEM_ADDR+1 bits).
REQ-002 Parameter MEM_EXTRA, default 4: access size field width; data bus is 2**MEM_EXTRA*8 bits (DW).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 m0_req  input  1  requester 0 (instruction fetch) read request, held until m0_gnt.
REQ-006 m0_addr  input  MEM_ADDR+1  requester 0 byte address.
REQ-007 m0_extra  input  MEM_EXTRA  requester 0 access size code.
REQ-008 m0_lower_bound, m0_upper_bound  input  MEM_ADDR+1 each  requester 0 legal window.
REQ-009 m0_gnt  output  1  one-cycle pulse: request 0 accepted.
REQ-010 m0_rvalid  output  1  one-cycle pulse: m0_rdata/m0_error valid.
REQ-011 m0_rdata  output  DW  read data to requester 0.
REQ-012 m0_error  output  1  ROM error for requester 0 access.
REQ-013 m1_* ports identical to REQ-005..REQ-012 for requester 1 (data/stack access).
REQ-014 mem_addr, mem_extra  output  MEM_ADDR+1, MEM_EXTRA  registered ROM address/size.
REQ-015 mem_lower_bound, mem_upper_bound  output  MEM_ADDR+1 each  registered bounds of current owner.
REQ-016 mem_data  input  DW  ROM data, valid one cycle after mem_addr sampled.
REQ-017 mem_error  input  1  ROM bound/range error, same timing as mem_data.

Function
REQ-018 FSM states IDLE, ADDR, DATA; exactly one ROM transaction in flight.
REQ-019 IDLE: if m0_req or m1_req at rising edge, arbitrate, latch winner addr/extra/bounds into mem_* registers, set winner gnt for the following cycle, go ADDR; else stay IDLE.
REQ-020 ADDR: gnt high for this cycle only; ROM samples mem_addr at its end; unconditional -> DATA.
REQ-021 DATA: at rising edge capture mem_data/mem_error into owner's rdata/error, assert owner's rvalid for the next cycle, -> IDLE.
REQ-022 Latency: req sampled at edge N -> gnt high cycle N+1 -> rvalid high cycle N+3; throughput one access per 3 cycles.
REQ-023 Arbitration round-robin: single contender wins; on simultaneous requests, the requester not granted last wins; last_owner resets to 1 so m0 wins the first tie.
REQ-024 A requester still holding req at the IDLE edge after its rvalid is treated as a new request (back-to-back allowed, fairness still applies).
REQ-025 mX_rdata holds its value until that requester's next rvalid; set to 0 when captured mem_error=1.
REQ-026 gnt and rvalid never asserted to both requesters in the same cycle; rvalid only to the granted owner.
REQ-027 mem_* outputs hold last transaction values while IDLE.
REQ-028 Requester inputs ignored outside IDLE arbitration edge; changes during ADDR/DATA do not affect the in-flight access.

Reset
REQ-029 reset asserted: state IDLE, last_owner=1, all gnt/rvalid/error=0, all rdata=0, mem_addr=0, mem_extra=0, mem_lower_bound=0, mem_upper_bound=0, immediately (asynchronously).
REQ-030 Reset during ADDR or DATA aborts the access: no rvalid is ever issued for it.
REQ-031 First arbitration occurs at the first rising edge after reset deasserts.

Verification
REQ-032 m0 alone, addr=0, extra=3, ROM word 0x0123456789ABCDEF -> m0_gnt cycle N+1, m0_rvalid cycle N+3, m0_rdata=0x0123456789ABCDEF, m0_error=0.
REQ-033 m0 and m1 assert same edge after reset -> m0 granted first, m1 gnt 3 cycles later; m1_rvalid 3 cycles after m0_rvalid.
REQ-034 Both held high continuously for 12 cycles -> grants alternate m0,m1,m0,m1; no double grant.
REQ-035 m1 addr=5 with m1_upper_bound=3 -> mem_upper_bound=3, ROM error, m1_error=1, m1_rdata=0, m0 outputs unchanged.
REQ-036 reset pulsed during DATA of m0 access -> no m0_rvalid, all outputs 0, next m1 request served normally.
